oam_dma: RTL

- Game Boy OAM DMA engine, written through register FF46.
- Sits upstream of the top-level address decode as a second bus master.
- While active, it drives source reads into the ROM/VRAM/WRAM decode and writes the fetched bytes to OAM (FE00-FE9F).
- The top level muxes its source address onto the decode while it is active, and blocks CPU bus access to everything except HRAM.

---
 rtl/gb_pkg.sv | 40 ++++
 rtl/oam_dma.sv | 111 +++++++++++
 2 files changed

// File: rtl/gb_pkg.sv
// Shared Game Boy definitions: bus address constants, the OAM DMA state
// encoding and the memory-region classification used by the address decode.
package gb_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_LEN      = 160;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    XFER,
    DRAIN
  } dma_state_t;

  // Coarse memory map regions; unusable FEA0-FEFF and IE (FFFF) fold into IO.
  typedef enum logic [2:0] {
    MEM_ROM,
    MEM_VRAM,
    MEM_XRAM,
    MEM_WRAM,
    MEM_ECHO,
    MEM_OAM,
    MEM_IO,
    MEM_HRAM
  } mem_region_t;

  function automatic mem_region_t mem_region(input logic [15:0] addr);
    if (addr < 16'h8000)      return MEM_ROM;
    else if (addr < 16'hA000) return MEM_VRAM;
    else if (addr < 16'hC000) return MEM_XRAM;
    else if (addr < 16'hE000) return MEM_WRAM;
    else if (addr < 16'hFE00) return MEM_ECHO;
    else if (addr < 16'hFEA0) return MEM_OAM;
    else if (addr < 16'hFF80) return MEM_IO;
    else if (addr == 16'hFFFF) return MEM_IO;
    else                      return MEM_HRAM;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine behind FF46. Acts as a second bus master: once written it
// reads LEN bytes from page {base, 00..LEN-1} and writes them to OAM one
// cycle later. The top level muxes src_addr onto the decode while active.
// Optional build macro OAM_DMA_ECHO_REMAP_EN folds source pages E0-FF down
// into WRAM (C0-DF); readback always returns the value actually written.
module oam_dma
  import gb_pkg::*;
#(
  parameter int LEN         = OAM_LEN,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        active,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        oam_write,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data
);

  localparam logic [7:0] LAST_IDX   = 8'(LEN - 1);
  localparam logic [7:0] DELAY_LAST = 8'(START_DELAY - 1);

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] base;
  logic [7:0] delay_cnt;
  logic [7:0] base_next;

  // Source page selected by a register write, optionally folded out of echo space
  always_comb begin
    base_next = reg_din;
`ifdef OAM_DMA_ECHO_REMAP_EN
    if (reg_din >= 8'hE0) begin
      base_next = reg_din - 8'h20;
    end
`endif
  end

  // Transfer FSM, index counter and read-to-write pipeline register; a register
  // write restarts from any state and discards the byte still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'h00;
      base      <= 8'h00;
      delay_cnt <= 8'h00;
      reg_dout  <= 8'hFF;
      active    <= 1'b0;
      src_rd    <= 1'b0;
      src_addr  <= 16'h0000;
      oam_write <= 1'b0;
      oam_addr  <= 8'h00;
      oam_data  <= 8'h00;
    end else if (reg_wr) begin
      reg_dout  <= reg_din;
      base      <= base_next;
      idx       <= 8'h00;
      delay_cnt <= 8'h00;
      state     <= DELAY;
      active    <= 1'b1;
      src_rd    <= 1'b0;
      src_addr  <= {base_next, 8'h00};
      oam_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          active    <= 1'b0;
          src_rd    <= 1'b0;
          oam_write <= 1'b0;
        end
        DELAY: begin
          if (delay_cnt == DELAY_LAST) begin
            state    <= XFER;
            idx      <= 8'h00;
            src_rd   <= 1'b1;
            src_addr <= {base, 8'h00};
          end else begin
            delay_cnt <= delay_cnt + 8'd1;
          end
        end
        XFER: begin
          oam_write <= 1'b1;
          oam_addr  <= idx;
          oam_data  <= src_data;
          if (idx == LAST_IDX) begin
            state  <= DRAIN;
            src_rd <= 1'b0;
          end else begin
            idx      <= idx + 8'd1;
            src_addr <= {base, idx + 8'd1};
          end
        end
        DRAIN: begin
          state     <= IDLE;
          active    <= 1'b0;
          oam_write <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
